audio_pdm_mixer: RTL and testbench

Mixes the chipset audio sources (PC speaker bit, JTOPL2 16-bit sample, Tandy 8-bit sample) into one signed 16-bit level. Applies volume attenuation and saturation, then drives the board audio pins through a first-order delta-sigma (PDM) modulator. It sits directly downstream of the CHIPSET audio outputs and replaces the raw speaker-bit drive of AUD_L/AUD_R. A mute state machine holds the output at mid-scale after reset or on request, which suppresses pops.

---
 rtl/audio_pdm_mixer_pkg.sv | 30 +++
 rtl/audio_pdm_mixer_if.sv | 30 +++
 rtl/audio_pdm_mixer_pdm.sv | 28 ++
 rtl/audio_pdm_mixer.sv | 149 ++++++++++++++
 tb/tb_audio_pdm_mixer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pdm_mixer_pkg.sv
// Shared constants, state encoding and saturation helper for the audio PDM mixer.
package audio_mixer_pkg;

    // Width of the summing path; three sources of at most 16 bits cannot overflow it.
    localparam int MIX_W = 18;

    // Modulator input that produces a 50% duty cycle (analog mid-scale).
    localparam logic [15:0] PDM_MID = 16'h8000;

    // Zero level of the unsigned Tandy/SN76489 sample.
    localparam logic [7:0] TANDY_MID = 8'd128;

    // Pop-suppression state machine encoding.
    typedef enum logic {
        MUTE = 1'b0,
        RUN  = 1'b1
    } mix_state_e;

    // Clamp an attenuated mix to the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic signed [MIX_W-1:0] v);
        if (v > 18'sd32767) begin
            return 16'h7FFF;
        end else if (v < -18'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/audio_pdm_mixer_if.sv
// Chipset-side audio sources and board audio pins grouped as one bundle.
interface audio_pdm_mixer_if;

    logic               sample_en;
    logic               speaker_in;
    logic signed [15:0] opl2_sample;
    logic        [7:0]  tandy_sample;
    logic               speaker_en;
    logic               opl2_en;
    logic               tandy_en;
    logic        [2:0]  volume;
    logic               mute_req;
    logic               AUD_L;
    logic               AUD_R;

    // Chipset side: drives the sources, observes the pins.
    modport master (
        output sample_en, speaker_in, opl2_sample, tandy_sample,
        output speaker_en, opl2_en, tandy_en, volume, mute_req,
        input  AUD_L, AUD_R
    );

    // Mixer side: consumes the sources, drives the pins.
    modport slave (
        input  sample_en, speaker_in, opl2_sample, tandy_sample,
        input  speaker_en, opl2_en, tandy_en, volume, mute_req,
        output AUD_L, AUD_R
    );

endinterface

// File: rtl/audio_pdm_mixer_pdm.sv
// First-order delta-sigma modulator: the carry out of a 16-bit phase
// accumulator is the PDM bit, so its density equals din / 65536.
module pdm_mod1 (
    input  logic        clk_chipset,
    input  logic        reset,
    input  logic [15:0] din,
    output logic        dout
);

    logic [15:0] acc_q;
    logic        dout_q;
    logic [16:0] acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, din};
    assign dout    = dout_q;

    // Accumulate the level; the carry becomes the registered output bit.
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            acc_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            acc_q  <= acc_sum[15:0];
            dout_q <= acc_sum[16];
        end
    end

endmodule

// File: rtl/audio_pdm_mixer.sv
// Mixes speaker, OPL2 and Tandy audio into one signed level, attenuates and
// saturates it, and drives AUD_L/AUD_R through a PDM modulator. A mute state
// machine parks the modulator at mid-scale after reset or on request.
module audio_pdm_mixer
    import audio_mixer_pkg::*;
#(
    parameter logic signed [15:0] SPK_LEVEL   = 16'sd8192,
    parameter int                 MUTE_CYCLES = 65536
) (
    input  logic             clk_chipset,
    input  logic             reset,
    audio_pdm_mixer_if.slave aud
);

    localparam int CNT_W = 20;

    // Stage 0 capture registers.
    logic signed [15:0]      opl2_q;
    logic        [7:0]       tandy_q;
    logic                    spk_q;
    logic                    spk_en_q;

    // Stage 1 / stage 2 pipeline registers.
    logic signed [MIX_W-1:0] sum_q;
    logic signed [MIX_W-1:0] sum_d;
    logic signed [15:0]      lvl_q;
    logic signed [15:0]      lvl_d;

    // Mute state machine.
    mix_state_e              state_q;
    mix_state_e              state_d;
    logic        [CNT_W-1:0] cnt_q;
    logic        [CNT_W-1:0] cnt_d;

    // Source conversion and modulator drive.
    logic signed [15:0]      opl2_s;
    logic        [7:0]       tandy_off;
    logic signed [13:0]      tandy_s;
    logic signed [15:0]      spk_s;
    logic signed [MIX_W-1:0] att;
    logic        [15:0]      u;
    logic        [15:0]      u_eff;
    logic                    pdm_bit;

    // Capture samples on the strobe; speaker bit and its enable every clock.
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            opl2_q   <= '0;
            tandy_q  <= TANDY_MID;
            spk_q    <= 1'b0;
            spk_en_q <= 1'b0;
        end else begin
            if (aud.sample_en) begin
                opl2_q  <= aud.opl2_sample;
                tandy_q <= aud.tandy_sample;
            end
            spk_q    <= aud.speaker_in;
            spk_en_q <= aud.speaker_en;
        end
    end

    // Convert each source to signed and sum with sign extension. The OPL2 and
    // Tandy enables act on the held samples so they take effect immediately.
    always_comb begin
        opl2_s    = aud.opl2_en ? opl2_q : 16'sd0;
        tandy_off = tandy_q - TANDY_MID;
        tandy_s   = aud.tandy_en ? $signed({tandy_off, 6'b000000}) : 14'sd0;
        spk_s     = 16'sd0;
        if (spk_en_q) begin
            spk_s = spk_q ? SPK_LEVEL : -SPK_LEVEL;
        end
        sum_d = {{(MIX_W-16){opl2_s[15]}}, opl2_s}
              + {{(MIX_W-14){tandy_s[13]}}, tandy_s}
              + {{(MIX_W-16){spk_s[15]}}, spk_s};
    end

    // Attenuate by an arithmetic shift, then clamp to 16 bits.
    always_comb begin
        att   = sum_q >>> aud.volume;
        lvl_d = $signed(sat16(att));
    end

    // Sum and scale pipeline registers.
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            sum_q <= '0;
            lvl_q <= '0;
        end else begin
            sum_q <= sum_d;
            lvl_q <= lvl_d;
        end
    end

    // Mute state register and settle counter.
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            state_q <= MUTE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: stay muted until MUTE_CYCLES quiet clocks have passed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MUTE: begin
                if (aud.mute_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(MUTE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (aud.mute_req) begin
                    state_d = MUTE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = MUTE;
                cnt_d   = '0;
            end
        endcase
    end

    // Offset-binary level for the modulator; mid-scale while muted.
    always_comb begin
        u     = {~lvl_q[15], lvl_q[14:0]};
        u_eff = (state_q == RUN) ? u : PDM_MID;
    end

    pdm_mod1 u_pdm (
        .clk_chipset (clk_chipset),
        .reset       (reset),
        .din         (u_eff),
        .dout        (pdm_bit)
    );

    assign aud.AUD_L = pdm_bit;
    assign aud.AUD_R = pdm_bit;

endmodule

// File: tb/tb_audio_pdm_mixer.sv
// Directed bench for audio_pdm_mixer: reset state, mute sequencing, mix,
// attenuation, saturation, latency and pulse density.
module tb_audio_pdm_mixer;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    audio_pdm_mixer_if aif ();

    audio_pdm_mixer #(
        .SPK_LEVEL   (16'sd8192),
        .MUTE_CYCLES (16)
    ) dut (
        .clk_chipset (clk),
        .reset       (reset),
        .aud         (aif.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A density count is within one pulse of the ideal n*u/65536.
    function automatic int near(input int v, input int e);
        return (v >= e - 1 && v <= e + 1) ? e : v;
    endfunction

    task automatic count_ones(input int n, output int ones, output int lr_diff);
        ones    = 0;
        lr_diff = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            ones    += int'(aif.AUD_L);
            lr_diff += (aif.AUD_L !== aif.AUD_R) ? 1 : 0;
        end
    endtask

    task automatic capture();
        aif.sample_en = 1'b1;
        tick();
        aif.sample_en = 1'b0;
    endtask

    task automatic window(input string tag, input int n, input int exp);
        int ones;
        int lrd;
        count_ones(n, ones, lrd);
        $display("window %s: %0d cycles, %0d ones", tag, n, ones);
        chk({tag, "_ones"}, near(ones, exp), exp);
        chk({tag, "_lr"}, lrd, 0);
    endtask

    int tv_in  [4] = '{0, 200, 255, 128};
    int tv_exp [4] = '{-2048, 1152, 2032, 0};

    initial begin
        int prev;
        int toggles;

        reset            = 1'b1;
        aif.sample_en    = 1'b0;
        aif.speaker_in   = 1'b0;
        aif.opl2_sample  = '0;
        aif.tandy_sample = '0;
        aif.speaker_en   = 1'b0;
        aif.opl2_en      = 1'b0;
        aif.tandy_en     = 1'b0;
        aif.volume       = 3'd0;
        aif.mute_req     = 1'b0;

        repeat (3) tick();
        chk("rst_aud_l", int'(aif.AUD_L), 0);
        chk("rst_aud_r", int'(aif.AUD_R), 0);
        chk("rst_state", int'(dut.state_q), 0);
        chk("rst_cnt", int'(dut.cnt_q), 0);
        chk("rst_lvl", int'(dut.lvl_q), 0);
        chk("rst_tandy", int'(dut.tandy_q), 128);
        $display("reset: aud=%0d state=%0d", aif.AUD_L, dut.state_q);

        // Release: mute pattern 0,1,0,1..., RUN after 16 clocks.
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("mute_seq%0d", k), int'(aif.AUD_L), (k % 2 == 0) ? 1 : 0);
            if (k == 15) chk("state_k15", int'(dut.state_q), 0);
            if (k == 16) chk("state_k16", int'(dut.state_q), 1);
        end
        $display("startup: state=%0d", dut.state_q);

        // Positive full scale, OPL2 only.
        aif.opl2_en     = 1'b1;
        aif.opl2_sample = 16'sh7FFF;
        capture();
        repeat (3) tick();
        chk("fs_lvl", int'(dut.lvl_q), 32767);
        window("fs", 4096, 4096);

        // All sources high: saturation without wraparound.
        aif.tandy_sample = 8'd255;
        aif.tandy_en     = 1'b1;
        aif.speaker_en   = 1'b1;
        aif.speaker_in   = 1'b1;
        capture();
        repeat (3) tick();
        chk("sat_sum", int'(dut.sum_q), 49087);
        chk("sat_lvl", int'(dut.lvl_q), 32767);
        window("sat", 2048, 2048);

        // Step to negative full scale: u changes 2 edges, AUD 3 edges after capture.
        aif.opl2_sample  = 16'sh8000;
        aif.tandy_sample = 8'd0;
        aif.speaker_in   = 1'b0;
        capture();
        chk("step_lvl_n0", int'(dut.lvl_q), 32767);
        tick();
        chk("step_lvl_n1", int'(dut.lvl_q), 32767);
        tick();
        chk("step_lvl_n2", int'(dut.lvl_q), -32768);
        chk("step_aud_n2", int'(aif.AUD_L), 1);
        tick();
        chk("step_aud_n3", int'(aif.AUD_L), 0);
        window("negfs", 1024, 0);

        // OPL2 0x4000 at volume 7 -> lvl 128, u 0x8080.
        aif.tandy_en    = 1'b0;
        aif.speaker_en  = 1'b0;
        aif.opl2_sample = 16'sh4000;
        aif.volume      = 3'd7;
        capture();
        repeat (3) tick();
        chk("vol7_lvl", int'(dut.lvl_q), 128);
        window("vol7", 4096, 2056);

        // OPL2 enable acts on the held sample without a new capture.
        aif.opl2_en = 1'b0;
        tick();
        chk("en_lvl_e1", int'(dut.lvl_q), 128);
        tick();
        chk("en_lvl_e2", int'(dut.lvl_q), 0);

        // Speaker only.
        aif.volume     = 3'd0;
        aif.speaker_en = 1'b1;
        aif.speaker_in = 1'b0;
        repeat (4) tick();
        chk("spk0_lvl", int'(dut.lvl_q), -8192);
        window("spk0", 4096, 1536);
        aif.speaker_in = 1'b1;
        repeat (4) tick();
        chk("spk1_lvl", int'(dut.lvl_q), 8192);
        window("spk1", 4096, 2560);

        // Tandy only, sample_en held high, volume 2.
        aif.speaker_en = 1'b0;
        aif.tandy_en   = 1'b1;
        aif.volume     = 3'd2;
        aif.sample_en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aif.tandy_sample = 8'(tv_in[i]);
            repeat (3) tick();
            chk($sformatf("tandy_%0d", tv_in[i]), int'(dut.lvl_q), tv_exp[i]);
            $display("tandy: in=%0d lvl=%0d", tv_in[i], dut.lvl_q);
        end
        aif.sample_en    = 1'b0;
        aif.tandy_sample = 8'd0;
        repeat (3) tick();
        chk("tandy_hold", int'(dut.lvl_q), 0);

        // Negative full scale, then a one-cycle mute pulse in RUN.
        aif.tandy_en    = 1'b0;
        aif.opl2_en     = 1'b1;
        aif.opl2_sample = 16'sh8000;
        aif.volume      = 3'd0;
        capture();
        repeat (3) tick();
        chk("pre_mute_state", int'(dut.state_q), 1);
        window("pre_mute", 64, 0);
        aif.mute_req = 1'b1;
        tick();
        aif.mute_req = 1'b0;
        chk("mute_state", int'(dut.state_q), 0);
        chk("mute_cnt", int'(dut.cnt_q), 0);
        toggles = 0;
        tick();
        chk("mute_cnt1", int'(dut.cnt_q), 1);
        prev = int'(aif.AUD_L);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (int'(aif.AUD_L) != prev) toggles++;
            prev = int'(aif.AUD_L);
        end
        chk("mute_toggles", toggles, 7);
        $display("mute pulse: toggles=%0d", toggles);

        // Held mute keeps the counter at zero; release restarts the 16-clock wait.
        aif.mute_req = 1'b1;
        repeat (4) tick();
        chk("hold_state", int'(dut.state_q), 0);
        chk("hold_cnt", int'(dut.cnt_q), 0);
        aif.mute_req = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 15) chk("rerun_k15", int'(dut.state_q), 0);
            if (k == 16) chk("rerun_k16", int'(dut.state_q), 1);
            if (k >= 17) chk($sformatf("rerun_aud%0d", k), int'(aif.AUD_L), 0);
        end

        // Reset in the middle of RUN.
        reset = 1'b1;
        tick();
        chk("mid_rst_aud", int'(aif.AUD_L), 0);
        chk("mid_rst_state", int'(dut.state_q), 0);
        chk("mid_rst_cnt", int'(dut.cnt_q), 0);
        chk("mid_rst_sum", int'(dut.sum_q), 0);
        chk("mid_rst_lvl", int'(dut.lvl_q), 0);
        chk("mid_rst_opl2", int'(dut.opl2_q), 0);
        chk("mid_rst_tandy", int'(dut.tandy_q), 128);
        chk("mid_rst_spk", int'(dut.spk_q), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_aud1", int'(aif.AUD_L), 0);
        tick();
        chk("post_rst_aud2", int'(aif.AUD_L), 1);
        $display("mid-run reset: state=%0d", dut.state_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
